byte_queue: RTL
===============

# byte_queue

Byte FIFO directly downstream of the deserializer. It accepts each assembled byte over the deserializer's data_ready/ack level handshake and stores it in a circular buffer. It hands bytes out in arrival order to the next consumer on request, and reports occupancy and full/empty flags.

## Interface
- DEPTH, 8, number of byte slots; power of two, ≥ 2
- WIDTH, 8, bits per entry
- clock_100  in  1  system clock (100 kHz domain), all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when 0
- data_in  in  WIDTH  byte from deserializer data_out
- data_ready_in  in  1  deserializer data_ready; byte on data_in is valid while high
- ack_out  out  1  to deserializer ack_in; one-cycle pulse confirming the byte was stored
- dequeue_in  in  1  consumer pop request, sampled each edge
- data_out  out  WIDTH  last popped byte, registered
- data_valid_out  out  1  one-cycle pulse: data_out was updated by a pop
- len_out  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  out  1  len_out == 0
- full  out  1  len_out == DEPTH

## Operation
- Storage: DEPTH×WIDTH register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, count of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH by natural overflow.
- Input FSM (3 states):
  - IDLE: if data_ready_in=1 and full=0 → write data_in at wr_ptr, wr_ptr+1, → ACK. If full=1 → stay in IDLE with no write and no ack; upstream holds its byte.
  - ACK: ack_out=1 (Moore output). Unconditionally → WAIT_RELEASE.
  - WAIT_RELEASE: no writes. If data_ready_in=0 → IDLE, else stay. This guarantees exactly one push per upstream byte, whatever delay upstream takes to drop data_ready.
- Output side, independent of the FSM: if dequeue_in=1 and empty=0 → data_out ← mem[rd_ptr], rd_ptr+1, data_valid_out=1 on the next cycle. If dequeue_in=1 and empty=1 → ignored; data_out holds and data_valid_out=0.
- Count: push only → +1; pop only → −1; push and pop on the same edge → unchanged, both performed.
- Full check uses the current count only. A pop on the same edge does not enable a push while full; the push occurs on the following edge.
- empty/full/len_out are combinational from count.
- Reset (reset=0, asynchronous): FSM→IDLE, pointers=0, count=0, data_out=0, data_valid_out=0, ack_out=0. Memory contents are not cleared and are unobservable. A byte mid-handshake at reset is dropped.
- After reset is released with data_ready_in still high, FSM is in IDLE and stores that byte as new.

## Timing
- Push latency: data_ready_in sampled high at edge k in IDLE (not full) → byte stored and len_out incremented after edge k; ack_out high for cycle k..k+1 exactly; FSM in WAIT_RELEASE from edge k+1.
- Minimum spacing between pushes: 3 edges (IDLE→ACK→WAIT_RELEASE→IDLE), assuming upstream drops data_ready within one cycle of ack.
- Pop latency: dequeue_in high at edge k → data_out/data_valid_out valid in cycle k..k+1, len_out decremented after edge k.
- Back-to-back pops every cycle are supported until empty.
- Reset reset=0 outputs: ack_out=0, data_out=0, data_valid_out=0, len_out=0, empty=1, full=0.

## Test plan
- Reset: hold reset=0 with data_ready_in=1 → all outputs at reset values, no ack; release → byte accepted on first edge.
- Single byte: present 0xAD with data_ready_in, drop it one cycle after ack → exactly one ack pulse, len_out=1; dequeue → data_out=0xAD, data_valid_out one cycle, empty=1.
- Fill/full: push 0x01..0x08 → full=1, len_out=8; present 0x09 → no ack while full. Single dequeue → data_out=0x01, then 0x09 acked on the next IDLE edge; len_out back to 8.
- Held data_ready: keep data_ready_in high 10 cycles after ack → only one push, len_out=1.
- Simultaneous: with len_out=3, push 0x5A on the same edge as a pop → len_out stays 3, popped value is the oldest entry, 0x5A appears in order later.
- Wrap and empty pop: push/pop 20 bytes 0x00..0x13 interleaved → output order identical. Dequeue on empty → no valid pulse, data_out unchanged. Assert reset=0 mid-ACK → ack_out drops immediately, len_out=0.

Source files
------------

// File: rtl/byte_queue.sv
// byte_queue: circular byte FIFO behind the deserializer.
// Level handshake on the write side, pop-on-request read side.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock_100,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_RELEASE
  } state_e;

  state_e           state_q;
  logic             ack_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] dout_q;
  logic             dvalid_q;
  logic             push;
  logic             pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign len_out = count_q;

  assign ack_out        = ack_q;
  assign data_out       = dout_q;
  assign data_valid_out = dvalid_q;

  // Full is judged on the current count; a same-edge pop never frees a slot early.
  assign push = (state_q == S_IDLE) && data_ready_in && !full;
  assign pop  = dequeue_in && !empty;

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write handshake: one push per upstream byte, wait for data_ready to drop.
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (push) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          state_q <= S_WAIT_RELEASE;
          ack_q   <= 1'b0;
        end
        S_WAIT_RELEASE: begin
          ack_q <= 1'b0;
          if (!data_ready_in) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are never observable before being written.
  always_ff @(posedge clock_100) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      dvalid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        dout_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule
